ac97_sample_arbiter: RTL and testbench

Round-robin arbiter that shares the AC97 controller's sample FIFO write port between two sample producers: requester 0 (CPU memory-mapped audio port) and requester 1 (hardware tone generator). Each requester gets a valid/ready stream; the arbiter grants bursts of up to `BURST_MAX` samples and issues registered FIFO writes, with a global mute and per-requester accepted-sample counters. It sits between the producers and the `ac97_controller` sample FIFO, on `cpu_clk_g`.

---
 rtl/ac97_sample_arbiter_pkg.sv | 26 ++
 rtl/ac97_sample_arbiter_if.sv | 36 +++
 rtl/ac97_sample_arbiter_sat_counter.sv | 27 ++
 rtl/ac97_sample_arbiter.sv | 143 ++++++++++++++
 tb/tb_ac97_sample_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ac97_sample_arbiter_pkg.sv
// Shared audio package for the AC97 sample arbiter.
// State encoding, requester indices and the default sample width.
package ac97_sample_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEF_SAMPLE_WIDTH = 20;

    function automatic logic [1:0] grant_onehot(input arb_state_e s);
        logic [1:0] g;
        case (s)
            ST_GRANT0: g = 2'b01;
            ST_GRANT1: g = 2'b10;
            default:   g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ac97_sample_arbiter_if.sv
// Producer streams and sample FIFO write port of the AC97 arbiter.
// master = producers/FIFO side, slave = arbiter.
interface ac97_sample_arbiter_if
    import ac97_sample_arbiter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) ();

    logic                    req0_valid;
    logic [SAMPLE_WIDTH-1:0] req0_data;
    logic                    req0_ready;
    logic                    req1_valid;
    logic [SAMPLE_WIDTH-1:0] req1_data;
    logic                    req1_ready;
    logic                    fifo_full;
    logic [SAMPLE_WIDTH-1:0] fifo_din;
    logic                    fifo_wr_en;
    logic [1:0]              grant;

    modport master (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        output fifo_full,
        input  req0_ready, req1_ready,
        input  fifo_din, fifo_wr_en, grant
    );

    modport slave (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        input  fifo_full,
        output req0_ready, req1_ready,
        output fifo_din, fifo_wr_en, grant
    );

endinterface

// File: rtl/ac97_sample_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ac97_sample_arbiter.sv
// Round-robin burst arbiter sharing the AC97 sample FIFO write port
// between the CPU audio port (req0) and the tone generator (req1).
module ac97_sample_arbiter
    import ac97_sample_arbiter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int BURST_MAX    = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 enable,
    input  logic                 mute,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1,
    ac97_sample_arbiter_if.slave bus
);

    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    arb_state_e              w_other_st;
    logic [BW-1:0]           r_burst_cnt;
    logic [BW-1:0]           w_burst_nxt;
    logic [BW-1:0]           w_burst_inc;
    logic                    r_last_grant;
    logic                    r_wr_en;
    logic [SAMPLE_WIDTH-1:0] r_din;

    logic w_open;
    logic w_rdy0;
    logic w_rdy1;
    logic w_acc0;
    logic w_acc1;
    logic w_acc;
    logic w_own_v;
    logic w_oth_v;
    logic w_burst_done;

    // No accept while a write is in flight: covers the 1-cycle full lag.
    assign w_open = enable & ~bus.fifo_full & ~r_wr_en;

    assign w_rdy0 = (r_state == ST_GRANT0) & w_open;
    assign w_rdy1 = (r_state == ST_GRANT1) & w_open;
    assign w_acc0 = bus.req0_valid & w_rdy0;
    assign w_acc1 = bus.req1_valid & w_rdy1;
    assign w_acc  = w_acc0 | w_acc1;

    assign w_own_v    = (r_state == ST_GRANT1) ? bus.req1_valid
                                               : bus.req0_valid;
    assign w_oth_v    = (r_state == ST_GRANT1) ? bus.req0_valid
                                               : bus.req1_valid;
    assign w_other_st = (r_state == ST_GRANT1) ? ST_GRANT0 : ST_GRANT1;

    assign w_burst_inc  = r_burst_cnt + BW'(w_acc);
    assign w_burst_done = (w_burst_inc == BW'(BURST_MAX));

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_burst_nxt = '0;
                if (enable && (bus.req0_valid || bus.req1_valid)) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        w_state_nxt = (r_last_grant == REQ1) ? ST_GRANT0
                                                             : ST_GRANT1;
                    end else if (bus.req0_valid) begin
                        w_state_nxt = ST_GRANT0;
                    end else begin
                        w_state_nxt = ST_GRANT1;
                    end
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_burst_nxt = '0;
                end else if (w_burst_done || !w_own_v) begin
                    w_burst_nxt = '0;
                    if (w_oth_v) begin
                        w_state_nxt = w_other_st;
                    end else if (!w_own_v) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_burst_nxt = w_burst_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_burst_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= ST_IDLE;
            r_burst_cnt  <= '0;
            r_last_grant <= REQ1;
            r_wr_en      <= 1'b0;
            r_din        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_wr_en     <= w_acc;
            if (w_acc) begin
                r_last_grant <= w_acc1 ? REQ1 : REQ0;
                if (mute) begin
                    r_din <= '0;
                end else begin
                    r_din <= w_acc1 ? bus.req1_data : bus.req0_data;
                end
            end
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.fifo_wr_en = r_wr_en;
    assign bus.fifo_din   = r_din;
    assign bus.grant      = grant_onehot(r_state);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt0 (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_clear (cnt_clear),
        .i_inc   (w_acc0),
        .o_count (cnt0)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt1 (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_clear (cnt_clear),
        .i_inc   (w_acc1),
        .o_count (cnt1)
    );

endmodule

// File: tb/tb_ac97_sample_arbiter.sv
// Bench for ac97_sample_arbiter: directed scenarios plus random
// traffic against a queue-based reference model of the arbitration rules.
module tb_ac97_sample_arbiter;

    localparam int SW   = 20;
    localparam int BMAX = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          enable = 1'b0;
    logic          mute = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    ac97_sample_arbiter_if #(.SAMPLE_WIDTH(SW)) bus ();

    ac97_sample_arbiter #(
        .SAMPLE_WIDTH (SW),
        .BURST_MAX    (BMAX),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .enable    (enable),
        .mute      (mute),
        .cnt_clear (cnt_clear),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [SW-1:0] q0[$];
    logic [SW-1:0] q1[$];
    logic [SW-1:0] wl_d[$];
    int            wl_t[$];

    // reference model: owner -1 = nobody, taken = samples in this burst
    int            m_owner;
    int            m_taken;
    int            m_last;
    bit            m_wr;
    logic [SW-1:0] m_din;
    int            m_c0;
    int            m_c1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wlog(input int k);
        if (k < wl_d.size()) return 32'(wl_d[k]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_taken = 0;
        m_last  = 1;
        m_wr    = 0;
        m_din   = '0;
        m_c0    = 0;
        m_c1    = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_ready"}, {bus.req1_ready, bus.req0_ready}, 0);
        check({tag, "_wr"}, 32'(bus.fifo_wr_en), 0);
        check({tag, "_din"}, 32'(bus.fifo_din), 0);
        check({tag, "_cnt0"}, 32'(cnt0), 0);
        check({tag, "_cnt1"}, 32'(cnt1), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_b = 1'b0;
        enable = 1'b0;
        mute = 1'b0;
        cnt_clear = 1'b0;
        bus.fifo_full = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        q0.delete();
        q1.delete();
        wl_d.delete();
        wl_t.delete();
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic step();
        bit            v0, v1, en, mu, cl, full, a0, a1, ov, xv;
        logic [SW-1:0] d0, d1;
        logic [1:0]    er;
        int            own, t, eg;
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        d0 = v0 ? q0[0] : '0;
        d1 = v1 ? q1[0] : '0;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_data  = d0;
        bus.req1_data  = d1;
        @(negedge clk);
        en = enable;
        mu = mute;
        cl = cnt_clear;
        full = bus.fifo_full;
        er[0] = (m_owner == 0) && en && !full && !m_wr;
        er[1] = (m_owner == 1) && en && !full && !m_wr;
        check("ready", {bus.req1_ready, bus.req0_ready}, 32'(er));
        a0 = v0 && er[0];
        a1 = v1 && er[1];
        @(posedge clk);
        #1;
        cyc++;
        if (cl) m_c0 = 0;
        else if (a0 && m_c0 < CMAX) m_c0++;
        if (cl) m_c1 = 0;
        else if (a1 && m_c1 < CMAX) m_c1++;
        if (m_owner < 0) begin
            m_taken = 0;
            if (en && (v0 || v1))
                m_owner = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
        end else if (!en) begin
            m_owner = -1;
            m_taken = 0;
        end else begin
            own = m_owner;
            ov = own ? v1 : v0;
            xv = own ? v0 : v1;
            t = m_taken + ((a0 || a1) ? 1 : 0);
            if (t == BMAX || !ov) begin
                m_taken = 0;
                if (xv) m_owner = 1 - own;
                else if (!ov) m_owner = -1;
            end else begin
                m_taken = t;
            end
        end
        m_wr = a0 || a1;
        if (m_wr) begin
            m_din = mu ? '0 : (a1 ? d1 : d0);
            m_last = a1 ? 1 : 0;
        end
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        eg = (m_owner == 0) ? 1 : ((m_owner == 1) ? 2 : 0);
        check("grant", 32'(bus.grant), eg);
        check("wr_en", 32'(bus.fifo_wr_en), 32'(m_wr));
        if (m_wr) check("din", 32'(bus.fifo_din), 32'(m_din));
        check("cnt0", 32'(cnt0), m_c0);
        check("cnt1", 32'(cnt1), m_c1);
        if (bus.fifo_wr_en) begin
            wl_d.push_back(bus.fifo_din);
            wl_t.push_back(cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad, base, blk, found;
        bus.fifo_full = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data = '0;
        bus.req1_data = '0;
        #1;

        // single requester stream
        do_reset("rst");
        enable = 1'b1;
        q0 = '{20'h00001, 20'h00002, 20'h00003};
        step();
        check("t1_grant", 32'(bus.grant), 1);
        repeat (7) step();
        check("t1_nwr", wl_d.size(), 3);
        for (int k = 0; k < 3; k++) check("t1_data", wlog(k), k + 1);
        check("t1_gap", (wl_t.size() >= 2) ? wl_t[1] - wl_t[0] : -1, 2);
        check("t1_cnt0", 32'(cnt0), 3);

        // both requesters saturated with traffic
        do_reset("rst2");
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            q0.push_back(SW'(32'h100 + k));
            q1.push_back(SW'(32'h200 + k));
        end
        repeat (30) step();
        for (int k = 0; k < 12; k++) begin
            blk = k / 4;
            base = (blk % 2) ? 32'h200 : 32'h100;
            check("t2_order", wlog(k), base + (blk / 2) * 4 + (k % 4));
        end
        bad = 0;
        for (int k = 1; k < 12 && k < wl_t.size(); k++)
            if (wl_t[k] - wl_t[k-1] != 2) bad++;
        check("t2_gaps", bad, 0);

        // fifo full mid-burst
        do_reset("rst3");
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            q0.push_back(SW'(32'h300 + k));
            q1.push_back(SW'(32'h400 + k));
        end
        for (int k = 0; k < 20 && wl_d.size() < 2; k++) step();
        check("t3_pre", wl_d.size(), 2);
        bus.fifo_full = 1'b1;
        repeat (10) step();
        check("t3_nowr", wl_d.size(), 2);
        check("t3_hold", 32'(bus.grant), 1);
        bus.fifo_full = 1'b0;
        repeat (20) step();
        check("t3_w2", wlog(2), 32'h302);
        check("t3_w3", wlog(3), 32'h303);
        check("t3_w4", wlog(4), 32'h400);

        // mute
        do_reset("rst4");
        enable = 1'b1;
        mute = 1'b1;
        q1.push_back(20'hABCDE);
        repeat (5) step();
        check("t4_nwr", wl_d.size(), 1);
        check("t4_din", wlog(0), 0);
        check("t4_cnt1", 32'(cnt1), 1);
        mute = 1'b0;

        // counter saturation, then clear racing an accept
        do_reset("rst5");
        enable = 1'b1;
        for (int k = 0; k < CMAX + 7; k++) q0.push_back(SW'($urandom));
        repeat (2 * (CMAX + 7) + 4) step();
        check("t5_sat", 32'(cnt0), CMAX);
        for (int k = 0; k < 10; k++) q0.push_back(SW'($urandom));
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (bus.fifo_wr_en) found = 1;
        end
        check("t5_wait", 32'(bus.fifo_wr_en), 1);
        step();
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        check("t5_clr_wr", 32'(bus.fifo_wr_en), 1);
        check("t5_clr_cnt", 32'(cnt0), 0);

        // enable dropped with a write pending, then reset mid-burst
        do_reset("rst6");
        enable = 1'b1;
        for (int k = 0; k < 6; k++) q1.push_back(SW'(32'h500 + k));
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (bus.fifo_wr_en) found = 1;
        end
        enable = 1'b0;
        #1;
        check("t6_pending", 32'(bus.fifo_wr_en), 1);
        check("t6_din", 32'(bus.fifo_din), 32'h500);
        step();
        check("t6_idle", 32'(bus.grant), 0);
        check("t6_rdy", {bus.req1_ready, bus.req0_ready}, 0);
        enable = 1'b1;
        repeat (3) step();
        do_reset("t7_midburst");

        // random traffic
        do_reset("rst8");
        repeat (3000) begin
            enable = ($urandom_range(0, 9) != 0);
            bus.fifo_full = ($urandom_range(0, 6) == 0);
            mute = ($urandom_range(0, 9) == 0);
            cnt_clear = ($urandom_range(0, 49) == 0);
            if (q0.size() < 4 && $urandom_range(0, 9) < 4)
                q0.push_back(SW'($urandom));
            if (q1.size() < 4 && $urandom_range(0, 9) < 4)
                q1.push_back(SW'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
